// File: rtl/booth2_mul_pkg.sv
// Shared definitions for the Booth-2 multiplier datapath: default sizing
// and the accumulator state encoding.
package booth2_mul_pkg;

   localparam int DEF_WIDTH  = 64;
   localparam int DEF_NUM_PP = 17;

   typedef enum logic [1:0] {
      ST_ACC  = 2'd0,
      ST_RSLV = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   // Beat-counter width able to hold 0..num_pp.
   function automatic int cnt_width(input int num_pp);
      return $clog2(num_pp + 1);
   endfunction

endpackage

// File: rtl/booth2_mul_csa_acc_if.sv
// Partial-product input and result output handshakes of the CSA accumulator.
interface booth2_mul_csa_acc_if
   import booth2_mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = cnt_width(DEF_NUM_PP)
);

   logic             pp_vld;
   logic             pp_rdy;
   logic [WIDTH-1:0] pp_dat;
   logic             pp_last;
   logic             res_vld;
   logic             res_rdy;
   logic [WIDTH-1:0] res_dat;
   logic [CNT_W-1:0] res_beats;

   modport master (
      output pp_vld, pp_dat, pp_last, res_rdy,
      input  pp_rdy, res_vld, res_dat, res_beats
   );

   modport slave (
      input  pp_vld, pp_dat, pp_last, res_rdy,
      output pp_rdy, res_vld, res_dat, res_beats
   );

endinterface

// File: rtl/booth2_mul_csa_row.sv
// WIDTH-bit 3:2 compressor row built from independent full adders.
// The carry vector is returned unshifted; the caller applies the weight.
module booth2_mul_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ c_i;
   assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module booth2_mul_csa_row #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   output logic [WIDTH-1:0] so_o,
   output logic [WIDTH-1:0] cout_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      booth2_mul_fa u_fa (
         .a_i  (a_i[i]),
         .b_i  (b_i[i]),
         .c_i  (c_i[i]),
         .s_o  (so_o[i]),
         .co_o (cout_o[i])
      );
   end

endmodule

// File: rtl/booth2_mul_csa_acc.sv
// Carry-save accumulator for the multi-cycle Booth-2 multiplier.
// Partial products are folded into redundant sum/carry registers, one per
// beat; a single registered carry-propagate add resolves the product.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_ACC  | taking beats, folding each into sum_q/carry_q
// ST_RSLV | one cycle: res_dat <= sum_q + (carry_q << 1)
// ST_OUT  | result presented, waiting for res_rdy
module booth2_mul_csa_acc
   import booth2_mul_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_PP = DEF_NUM_PP
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   booth2_mul_csa_acc_if.slave bus
);

   localparam int CNT_W = cnt_width(NUM_PP);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] carry_q, carry_d;
   logic [WIDTH-1:0] carry_sh;
   logic [WIDTH-1:0] row_s, row_c;
   logic [WIDTH-1:0] res_dat_q, res_dat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] res_beats_q, res_beats_d;
   logic             beat_acc;
   logic             beat_last;

   // Carry bits carry the next bit's weight; the MSB falls off here.
   assign carry_sh = carry_q << 1;

   booth2_mul_csa_row #(.WIDTH(WIDTH)) u_row (
      .a_i    (sum_q),
      .b_i    (carry_sh),
      .c_i    (bus.pp_dat),
      .so_o   (row_s),
      .cout_o (row_c)
   );

   assign beat_acc  = (state_q == ST_ACC) && bus.pp_vld;
   // Reaching NUM_PP beats ends the operation whatever pp_last says.
   assign beat_last = bus.pp_last || (cnt_q == CNT_W'(NUM_PP - 1));

   // Next-state logic; clr overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACC:  if (beat_acc && beat_last) state_d = ST_RSLV;
         ST_RSLV: state_d = ST_OUT;
         ST_OUT:  if (bus.res_rdy) state_d = ST_ACC;
         default: state_d = ST_ACC;
      endcase
      if (clr) state_d = ST_ACC;
   end

   // Datapath next values: fold, resolve, or clear after the handoff.
   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      res_dat_d   = res_dat_q;
      res_beats_d = res_beats_q;
      if (clr) begin
         sum_d   = '0;
         carry_d = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (bus.pp_vld) begin
                  sum_d   = row_s;
                  carry_d = row_c;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            ST_RSLV: begin
               res_dat_d   = sum_q + carry_sh;
               res_beats_d = cnt_q;
            end
            ST_OUT: begin
               if (bus.res_rdy) begin
                  sum_d   = '0;
                  carry_d = '0;
                  cnt_d   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         sum_q       <= '0;
         carry_q     <= '0;
         cnt_q       <= '0;
         res_dat_q   <= '0;
         res_beats_q <= '0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         res_dat_q   <= res_dat_d;
         res_beats_q <= res_beats_d;
      end
   end

   assign bus.pp_rdy    = (state_q == ST_ACC);
   assign bus.res_vld   = (state_q == ST_OUT);
   assign bus.res_dat   = res_dat_q;
   assign bus.res_beats = res_beats_q;

endmodule
